// File: rtl/u0_normalize_pkg.sv
// Shared AWGN datapath definitions: uniform word width, exponent width and
// the normalised result record passed on to the log evaluator.
package u0_normalize_pkg;

  localparam int unsigned U0_W  = 48;
  localparam int unsigned U0_CW = 6;

  typedef struct packed {
    logic [U0_CW-1:0] exp_e;
    logic [U0_W-1:0]  mant_x;
    logic             zero;
  } norm_rec_t;

endpackage

// File: rtl/u0_normalize_lzd.sv
// 48-bit leading-zero detector: count of zeros above the first one, plus a
// flag that is low when the word is all-zero (count is then 0).
module lzd48 (
  input  logic [47:0] d,
  output logic [5:0]  cnt,
  output logic        nz
);

  always_comb begin
    cnt = '0;
    nz  = 1'b0;
    for (int unsigned i = 0; i < 48; i++) begin
      if (!nz && d[47-i]) begin
        cnt = 6'(i);
        nz  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/u0_normalize_shift.sv
// 48-bit logarithmic left shifter, six mux levels, zero fill. Shift amounts
// of 48 or more produce zero.
module norm_shift48 (
  input  logic [47:0] d,
  input  logic [5:0]  amt,
  output logic [47:0] q
);

  logic [47:0] lvl [0:6];

  assign lvl[0] = d;

  for (genvar k = 0; k < 6; k++) begin : g_lvl
    assign lvl[k+1] = amt[k] ? (lvl[k] << (1 << k)) : lvl[k];
  end

  assign q = lvl[6];

endmodule

// File: rtl/u0_normalize.sv
// Normaliser for the uniform word u0: u = 2^-e * x with x MSB set, in a
// two-stage valid/ready pipeline (S1: capture + lzc, S2: shifted result).
module u0_normalize
  import u0_normalize_pkg::*;
#(
  parameter int unsigned W  = U0_W,
  parameter int unsigned CW = U0_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  u0,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] exp_e,
  output logic [W-1:0]  mant_x,
  output logic          zero,
  output logic [15:0]   zero_cnt
);

  logic          s1_valid;
  logic [W-1:0]  s1_u0;
  logic [CW-1:0] s1_lzc;
  logic          s1_zero;
  logic          s2_valid;
  norm_rec_t     s2_q;

  logic          s1_adv;
  logic          s2_adv;
  logic          in_fire;
  logic [5:0]    lzd_cnt;
  logic          lzd_nz;
  logic [W-1:0]  shifted;

  lzd48 u_lzd (
    .d   (u0),
    .cnt (lzd_cnt),
    .nz  (lzd_nz)
  );

  norm_shift48 u_shift (
    .d   (s1_u0),
    .amt (s1_lzc),
    .q   (shifted)
  );

  // Ready depends only on out_ready and the stage valid bits, never on in_valid.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
    in_fire  = in_valid && s1_adv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_u0    <= '0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
      zero_cnt <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_u0   <= u0;
          s1_lzc  <= lzd_nz ? CW'(lzd_cnt) : CW'(W);
          s1_zero <= !lzd_nz;
        end
      end
      if (in_fire && !lzd_nz && zero_cnt != '1) begin
        zero_cnt <= zero_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_q.exp_e  <= s1_zero ? '0 : s1_lzc + CW'(1);
        s2_q.mant_x <= s1_zero ? '0 : shifted;
        s2_q.zero   <= s1_zero;
      end
    end
  end

  assign out_valid = s2_valid;
  assign exp_e     = s2_q.exp_e;
  assign mant_x    = s2_q.mant_x;
  assign zero      = s2_q.zero;

endmodule

// File: tb/tb_u0_normalize.sv
// Randomised check of u0_normalize against an arithmetic reference model,
// with directed vectors, stall, reset and zero-count saturation cases.
module tb_u0_normalize;

  localparam int unsigned W  = 48;
  localparam int unsigned CW = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  u0;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] exp_e;
  logic [W-1:0]  mant_x;
  logic          zero;
  logic [15:0]   zero_cnt;

  u0_normalize #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u0        (u0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_e     (exp_e),
    .mant_x    (mant_x),
    .zero      (zero),
    .zero_cnt  (zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errs   = 0;
  int unsigned checks = 0;

  logic [W-1:0]  q[$];
  int unsigned   zmodel = 0;
  logic          hold_pend = 1'b0;
  logic [CW-1:0] prev_e;
  logic [W-1:0]  prev_x;
  logic          prev_z;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Value-level model: double the fraction until its top bit is set.
  function automatic void ref_norm(input logic [W-1:0] u, output int unsigned e,
                                   output logic [W-1:0] x, output logic z);
    longint unsigned v;
    if (u == '0) begin
      e = 0; x = '0; z = 1'b1;
    end else begin
      v = longint'(u);
      e = 1;
      while (v < 64'h8000_0000_0000) begin
        v = v * 2;
        e++;
      end
      x = v[W-1:0];
      z = 1'b0;
    end
  endfunction

  function automatic logic [W-1:0] rnd_u0();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 15) == 0) return '0;
    return r[W-1:0] >> $urandom_range(0, 47);
  endfunction

  // Inputs are set by the caller just after a negedge; sample 1ns later.
  task automatic cycle();
    int unsigned e;
    logic [W-1:0] x;
    logic z;
    logic [W-1:0] u;
    #1;
    chk("zero_cnt", zero_cnt, zmodel);
    if (hold_pend) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_exp", exp_e, prev_e);
      chk("hold_mant", mant_x, prev_x);
      chk("hold_zero", zero, prev_z);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        u = q.pop_front();
        ref_norm(u, e, x, z);
        chk("sb_exp", exp_e, e);
        chk("sb_mant", mant_x, x);
        chk("sb_zero", zero, z);
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(u0);
      if (u0 == '0 && zmodel != 65535) zmodel++;
    end
    hold_pend = out_valid && !out_ready;
    prev_e = exp_e;
    prev_x = mant_x;
    prev_z = zero;
    @(negedge clk);
  endtask

  task automatic dir(input string tag, input logic [W-1:0] u, input logic [CW-1:0] e,
                     input logic [W-1:0] x, input logic z);
    in_valid  = 1'b1;
    u0        = u;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    cycle();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_exp"}, exp_e, e);
    chk({tag, "_mant"}, mant_x, x);
    chk({tag, "_zero"}, zero, z);
    cycle();
  endtask

  task automatic drain();
    int unsigned n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      cycle();
      n++;
    end
    chk("drain_left", q.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    zmodel    = 0;
    hold_pend = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_zero_cnt", zero_cnt, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    u0        = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_exp", exp_e, 0);
    chk("reset_mant", mant_x, 0);
    chk("reset_zero", zero, 0);
    chk("reset_zero_cnt", zero_cnt, 0);
    rst = 1'b0;
    chk("reset_in_ready", in_ready, 1);

    dir("msb", 48'h8000_0000_0000, 6'd1, 48'h8000_0000_0000, 1'b0);
    dir("lsb", 48'h0000_0000_0001, 6'd48, 48'h8000_0000_0000, 1'b0);
    dir("mid", 48'h0000_0001_2345, 6'd32, 48'h91A2_8000_0000, 1'b0);
    dir("zero", 48'h0, 6'd0, 48'h0, 1'b1);
    chk("zero_cnt_one", zero_cnt, 1);

    // Fill from empty with the output blocked: two accepts, then backpressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      u0 = rnd_u0();
      chk("fill_in_ready", in_ready, 1);
      cycle();
    end
    chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      u0 = rnd_u0();
      cycle();
      chk("stall_in_ready_hold", in_ready, 0);
    end

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      u0        = rnd_u0();
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    u0        = rnd_u0();
    cycle();
    u0 = rnd_u0();
    cycle();
    chk("pre_rst_full", out_valid, 1);
    do_reset();
    dir("post_rst", 48'h0000_0400_0000, 6'd22, 48'h8000_0000_0000, 1'b0);

    in_valid  = 1'b1;
    u0        = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) cycle();
    drain();
    chk("zero_cnt_sat", zero_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
